// File: rtl/logic_test_pkg.sv
// Shared types and constants for the AND/OR logic-unit sweep controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package logic_test_pkg;

    // Controller states; prefixed so they never collide with the SETTLE parameter.
    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } sweepState_t;

    localparam int DEFAULT_WIDTH  = 2;
    localparam int DEFAULT_SETTLE = 2;

    // Expected {x&y, x|y} for one operand pair at the default width.
    function automatic logic [2*DEFAULT_WIDTH-1:0] vec_expected(
        input logic [DEFAULT_WIDTH-1:0] x,
        input logic [DEFAULT_WIDTH-1:0] y
    );
        return {x & y, x | y};
    endfunction

endpackage

// File: rtl/logic_ref_model.sv
// Combinational expected-result generator for the bitwise AND/OR unit.
// Latency: zero cycles, purely combinational.
// Backpressure: none; outputs follow the operands continuously.
module logic_ref_model
    import logic_test_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] andExp,
    output logic [WIDTH-1:0] orExp
);

    assign andExp = x & y;
    assign orExp  = x | y;

endmodule

// File: rtl/logic_sweep_ctrl.sv
// Clocked sequencer that sweeps every (x, y) pair through the AND/OR unit and checks results.
// Latency: SETTLE+2 cycles per vector; DONE entered 2^(2*WIDTH)*(SETTLE+2) edges after start.
// Backpressure: none; start is ignored while busy or in DONE, abort ends a sweep early.
module logic_sweep_ctrl
    import logic_test_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int SETTLE = DEFAULT_SETTLE
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    output logic [WIDTH-1:0]   x_out,
    output logic [WIDTH-1:0]   y_out,
    input  logic [WIDTH-1:0]   and_in,
    input  logic [WIDTH-1:0]   or_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic [2*WIDTH-1:0] first_fail
);

    localparam int              VW          = 2 * WIDTH;
    localparam logic [VW-1:0]   LAST_IDX    = '1;
    localparam logic [VW:0]     ERR_MAX     = '1;
    // Final settle count value; unused when SETTLE is zero because SETTLE is then skipped.
    localparam logic [3:0]      SETTLE_LAST = 4'((SETTLE == 0) ? 0 : SETTLE - 1);

    sweepState_t     state;
    logic [VW-1:0]   idx;
    logic [3:0]      settleCnt;
    logic [WIDTH-1:0] expAnd;
    logic [WIDTH-1:0] expOr;
    logic            mismatch;
    logic [VW:0]     errNext;

    logic_ref_model #(.WIDTH(WIDTH)) uRef (
        .x      (x_out),
        .y      (y_out),
        .andExp (expAnd),
        .orExp  (expOr)
    );

    // Compare the unit's answer for the held operands and form the saturating error count.
    always_comb begin
        mismatch = (and_in != expAnd) || (or_in != expOr);
        errNext  = err_count;
        if (mismatch && (err_count != ERR_MAX)) begin
            errNext = err_count + 1'b1;
        end
    end

    // Sweep FSM with all outputs registered; abort and last-vector both funnel into DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            settleCnt  <= '0;
            x_out      <= '0;
            y_out      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    x_out <= '0;
                    y_out <= '0;
                    if (start) begin
                        err_count  <= '0;
                        pass       <= 1'b0;
                        first_fail <= '0;
                        idx        <= '0;
                        settleCnt  <= '0;
                        busy       <= 1'b1;
                        state      <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        x_out     <= idx[VW-1:WIDTH];
                        y_out     <= idx[WIDTH-1:0];
                        settleCnt <= '0;
                        state     <= (SETTLE > 0) ? S_SETTLE : S_CHECK;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                        state <= S_DONE;
                    end else if (settleCnt == SETTLE_LAST) begin
                        state <= S_CHECK;
                    end else begin
                        settleCnt <= settleCnt + 4'd1;
                    end
                end
                S_CHECK: begin
                    // The comparison is recorded even when abort lands on this cycle.
                    err_count <= errNext;
                    if (mismatch && (err_count == '0)) begin
                        first_fail <= idx;
                    end
                    if (abort || (idx == LAST_IDX)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !abort && (errNext == '0);
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    x_out <= '0;
                    y_out <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
